// File: rtl/button_event_arbiter_if.sv
// Event port between the button arbiter and the downstream command FSM.
// Ports: evt_valid/evt_id come from the arbiter (master); evt_ready comes back from the consumer (slave).
// evt_id is a button index and must stay stable while evt_valid is high.
interface button_event_arbiter_if #(
  parameter int ID_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/button_event_arbiter.sv
// Push-button front end: 2-FF synchroniser, tick-based debounce, press queueing and round-robin event serialiser.
// Ports: clk, rst (async, active high), btn_in raw levels, ovf_clr, btn_level debounced levels, ovf sticky loss flag,
//        evt (master side of the event valid/ready port).
// Latency: press to evt_valid is one clk after pending sets. Backpressure: an offer holds until evt_ready.
module button_event_arbiter #(
  parameter int N_BTN      = 4,
  parameter int ID_W       = 2,
  parameter int TICK_DIV   = 50000,
  parameter int STABLE_CNT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  btn_in,
  input  logic              ovf_clr,
  output logic [N_BTN-1:0]  btn_level,
  output logic              ovf,
  button_event_arbiter_if.master evt
);

  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic {IDLE, OFFER} state_t;

  logic [N_BTN-1:0] sync1, sync2;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [3:0]       cnt [N_BTN];
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] clr_vec;
  logic             accept;
  logic             found;
  logic [ID_W-1:0]  pick;
  state_t           state, state_nx;
  logic [ID_W-1:0]  id_q, id_nx;
  logic [ID_W-1:0]  ptr, ptr_nx;

  // Synchroniser and sample-tick divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      tick_cnt <= '0;
    end else begin
      sync1    <= btn_in;
      sync2    <= sync1;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  // A level flips only after STABLE_CNT consecutive disagreeing samples;
  // any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2[i] == btn_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == 4'(STABLE_CNT - 1)) begin
          btn_level[i] <= ~btn_level[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  // A press is the 0->1 flip happening on this edge.
  always_comb begin
    press = '0;
    for (int i = 0; i < N_BTN; i++)
      press[i] = tick & sync2[i] & ~btn_level[i] & (cnt[i] == 4'(STABLE_CNT - 1));
  end

  assign accept = (state == OFFER) && evt.evt_ready;

  always_comb begin
    clr_vec = '0;
    if (accept) clr_vec[id_q] = 1'b1;
  end

  // A new press ORs in after the clear, so a press on the channel being
  // accepted re-arms it instead of being counted as lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      ovf     <= 1'b0;
    end else begin
      pending <= (pending & ~clr_vec) | press;
      if (|(press & pending & ~clr_vec)) ovf <= 1'b1;
      else if (ovf_clr)                  ovf <= 1'b0;
    end
  end

  // First pending channel at or above ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_BTN; k++) begin
      if (!found && pending[(int'(ptr) + k) % N_BTN]) begin
        found = 1'b1;
        pick  = ID_W'((int'(ptr) + k) % N_BTN);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      id_q  <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      id_q  <= id_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    id_nx    = id_q;
    ptr_nx   = ptr;
    case (state)
      IDLE: begin
        if (found) begin
          id_nx    = pick;
          state_nx = OFFER;
        end
      end
      OFFER: begin
        if (evt.evt_ready) begin
          state_nx = IDLE;
          ptr_nx   = ID_W'((int'(id_q) + 1) % N_BTN);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign evt.evt_valid = (state == OFFER);
  assign evt.evt_id    = id_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
module tb_button_event_arbiter;
  localparam int N  = 4;
  localparam int TD = 4;
  localparam int SC = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic         ovf_clr = 1'b0;
  logic [N-1:0] btn_level;
  logic         ovf;

  button_event_arbiter_if #(.ID_W(2)) bus ();

  button_event_arbiter #(.N_BTN(N), .ID_W(2), .TICK_DIV(TD), .STABLE_CNT(SC)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .ovf_clr(ovf_clr),
    .btn_level(btn_level), .ovf(ovf), .evt(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Behavioural reference: spec rules applied once per clock edge.
  bit [N-1:0] m_sync1, m_sync2, m_lvl, m_pend;
  int         m_run [N];
  int         m_phase, m_id, m_ptr;
  bit         m_off, m_ovf;

  // Handshakes observed on the DUT port.
  int dut_log[$];
  int dut_cyc[$];

  task automatic model_reset();
    m_sync1 = '0; m_sync2 = '0; m_lvl = '0; m_pend = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_phase = 0; m_id = 0; m_ptr = 0; m_off = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit [N-1:0] b, input bit r, input bit c);
    bit         tick;
    bit [N-1:0] press, clrv, newlvl;
    int         newrun [N];
    bit         acc;
    tick   = (m_phase == TD - 1);
    press  = '0;
    newlvl = m_lvl;
    for (int i = 0; i < N; i++) begin
      newrun[i] = m_run[i];
      if (tick) begin
        if (m_sync2[i] != m_lvl[i]) begin
          if (m_run[i] + 1 == SC) begin
            newlvl[i] = ~m_lvl[i];
            newrun[i] = 0;
            if (!m_lvl[i]) press[i] = 1;
          end else newrun[i] = m_run[i] + 1;
        end else newrun[i] = 0;
      end
    end
    acc  = m_off && r;
    clrv = '0;
    if (acc) clrv[m_id] = 1;
    if ((press & m_pend & ~clrv) != 0) m_ovf = 1;
    else if (c) m_ovf = 0;
    if (acc) begin
      m_off = 0;
      m_ptr = (m_id + 1) % N;
    end else if (!m_off && m_pend != 0) begin
      for (int k = N - 1; k >= 0; k--)
        if (m_pend[(m_ptr + k) % N]) m_id = (m_ptr + k) % N;
      m_off = 1;
    end
    m_pend  = (m_pend & ~clrv) | press;
    m_lvl   = newlvl;
    for (int i = 0; i < N; i++) m_run[i] = newrun[i];
    m_sync2 = m_sync1;
    m_sync1 = b;
    m_phase = (m_phase + 1) % TD;
  endtask

  // True if the reference expects a press of channel i on the coming edge.
  function automatic bit model_press_next(input int i);
    return (m_phase == TD - 1) && m_sync2[i] && !m_lvl[i] && (m_run[i] == SC - 1);
  endfunction

  task automatic cycle(input bit [N-1:0] b, input bit r, input bit c);
    btn_in = b; bus.evt_ready = r; ovf_clr = c;
    if (bus.evt_valid && r && !rst) begin
      dut_log.push_back(int'(bus.evt_id));
      dut_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (rst) model_reset(); else model_step(b, r, c);
    #1;
    cyc++;
    checks++; if (btn_level !== m_lvl) begin fails++; $display("FAIL btn_level cyc=%0d got=%b exp=%b", cyc, btn_level, m_lvl); end
    checks++; if (bus.evt_valid !== m_off) begin fails++; $display("FAIL evt_valid cyc=%0d got=%b exp=%b", cyc, bus.evt_valid, m_off); end
    checks++; if (bus.evt_id !== 2'(m_id)) begin fails++; $display("FAIL evt_id cyc=%0d got=%0d exp=%0d", cyc, bus.evt_id, m_id); end
    checks++; if (ovf !== m_ovf) begin fails++; $display("FAIL ovf cyc=%0d got=%b exp=%b", cyc, ovf, m_ovf); end
  endtask

  task automatic hold(input bit [N-1:0] b, input bit r, input bit c, input int n);
    for (int k = 0; k < n; k++) cycle(b, r, c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hold('0, 1'b0, 1'b0, 3);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({btn_level, bus.evt_valid, bus.evt_id, ovf} !== '0) begin fails++; $display("FAIL reset_outputs got=%b exp=0", {btn_level, bus.evt_valid, bus.evt_id, ovf}); end
    hold(4'b0010, 1'b0, 1'b0, 24);
    hold(4'b0000, 1'b0, 1'b0, 24);
    checks++; if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd1) begin fails++; $display("FAIL reset_preoffer got=%b/%0d exp=1/1", bus.evt_valid, bus.evt_id); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.evt_valid !== 1'b0) begin fails++; $display("FAIL async_rst_valid got=%b exp=0", bus.evt_valid); end
    checks++; if (bus.evt_id !== 2'd0) begin fails++; $display("FAIL async_rst_id got=%0d exp=0", bus.evt_id); end
    checks++; if (btn_level !== '0 || ovf !== 1'b0) begin fails++; $display("FAIL async_rst_misc got=%b/%b exp=0/0", btn_level, ovf); end
    model_reset();
    hold('0, 1'b0, 1'b0, 2);
    rst = 1'b0;
    dut_log.delete();
    hold('0, 1'b1, 1'b0, 30);
    checks++; if (dut_log.size() != 0) begin fails++; $display("FAIL reset_no_event got=%0d exp=0", dut_log.size()); end
  endtask

  task automatic test_clean_press();
    int n = 0;
    bit seen = 0;
    dut_log.delete();
    for (int k = 0; k < 20 && !seen; k++) begin
      cycle(4'b0100, 1'b1, 1'b0);
      n++;
      if (btn_level[2]) seen = 1;
    end
    checks++; if (!seen || n > 14) begin fails++; $display("FAIL press_latency got=%0d clk (seen=%b) exp<=14", n, seen); end
    checks++; if (bus.evt_valid !== 1'b0) begin fails++; $display("FAIL press_valid_early got=%b exp=0", bus.evt_valid); end
    cycle(4'b0100, 1'b1, 1'b0);
    checks++; if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd2) begin fails++; $display("FAIL press_offer got=%b/%0d exp=1/2", bus.evt_valid, bus.evt_id); end
    hold(4'b0100, 1'b1, 1'b0, 4);
    hold(4'b0000, 1'b1, 1'b0, 30);
    checks++; if (dut_log.size() != 1 || dut_log[0] != 2) begin fails++; $display("FAIL press_one_event got=%0d events first=%0d exp=1 events id 2", dut_log.size(), dut_log[0]); end
    checks++; if (btn_level !== 4'b0000) begin fails++; $display("FAIL release_level got=%b exp=0000", btn_level); end
  endtask

  task automatic test_bounce();
    bit glitch = 0;
    int rises = 0;
    bit prev;
    dut_log.delete();
    for (int k = 0; k < 40; k++) begin
      cycle(((k / 4) % 2) ? 4'b0010 : 4'b0000, 1'b1, 1'b0);
      if (btn_level[1]) glitch = 1;
    end
    checks++; if (glitch) begin fails++; $display("FAIL bounce_glitch got=1 exp=0"); end
    prev = btn_level[1];
    for (int k = 0; k < 30; k++) begin
      cycle(4'b0010, 1'b1, 1'b0);
      if (btn_level[1] && !prev) rises++;
      prev = btn_level[1];
    end
    checks++; if (rises != 1) begin fails++; $display("FAIL bounce_rises got=%0d exp=1", rises); end
    checks++; if (dut_log.size() != 1 || dut_log[0] != 1) begin fails++; $display("FAIL bounce_event got=%0d events first=%0d exp=1 events id 1", dut_log.size(), dut_log[0]); end
    hold(4'b0000, 1'b1, 1'b0, 30);
  endtask

  task automatic test_simultaneous();
    do_reset();
    dut_log.delete(); dut_cyc.delete();
    hold(4'b1001, 1'b1, 1'b0, 24);
    checks++; if (dut_log.size() != 2 || dut_log[0] != 0 || dut_log[1] != 3) begin fails++; $display("FAIL simul_order1 got=%0d:%0d,%0d exp=2:0,3", dut_log.size(), dut_log[0], dut_log[1]); end
    checks++; if (dut_cyc.size() != 2 || dut_cyc[1] - dut_cyc[0] != 2) begin fails++; $display("FAIL simul_gap got=%0d exp=2", dut_cyc[1] - dut_cyc[0]); end
    hold(4'b0000, 1'b1, 1'b0, 24);
    dut_log.delete();
    hold(4'b1001, 1'b1, 1'b0, 24);
    checks++; if (dut_log.size() != 2 || dut_log[0] != 0 || dut_log[1] != 3) begin fails++; $display("FAIL simul_order2 got=%0d:%0d,%0d exp=2:0,3", dut_log.size(), dut_log[0], dut_log[1]); end
    hold(4'b0000, 1'b1, 1'b0, 24);
    hold(4'b0001, 1'b1, 1'b0, 24);
    hold(4'b0000, 1'b1, 1'b0, 24);
    dut_log.delete();
    hold(4'b1001, 1'b1, 1'b0, 24);
    checks++; if (dut_log.size() != 2 || dut_log[0] != 3 || dut_log[1] != 0) begin fails++; $display("FAIL simul_order3 got=%0d:%0d,%0d exp=2:3,0", dut_log.size(), dut_log[0], dut_log[1]); end
    hold(4'b0000, 1'b1, 1'b0, 24);
  endtask

  task automatic test_overflow();
    bit fired = 0;
    bit c;
    dut_log.delete();
    hold(4'b0001, 1'b0, 1'b0, 24);
    hold(4'b0000, 1'b0, 1'b0, 24);
    hold(4'b0001, 1'b0, 1'b0, 24);
    checks++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_set got=%b exp=1", ovf); end
    checks++; if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd0) begin fails++; $display("FAIL ovf_offer_hold got=%b/%0d exp=1/0", bus.evt_valid, bus.evt_id); end
    hold(4'b0001, 1'b1, 1'b0, 12);
    checks++; if (dut_log.size() != 1 || dut_log[0] != 0) begin fails++; $display("FAIL ovf_one_event got=%0d exp=1", dut_log.size()); end
    checks++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    cycle(4'b0001, 1'b1, 1'b1);
    checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
    hold(4'b0000, 1'b1, 1'b0, 24);
    hold(4'b0001, 1'b0, 1'b0, 24);
    hold(4'b0000, 1'b0, 1'b0, 24);
    for (int k = 0; k < 24; k++) begin
      c = model_press_next(0);
      if (c) fired = 1;
      cycle(4'b0001, 1'b0, c);
    end
    checks++; if (!fired || ovf !== 1'b1) begin fails++; $display("FAIL ovf_set_wins got=%b (fired=%b) exp=1", ovf, fired); end
    hold(4'b0000, 1'b1, 1'b0, 24);
    cycle(4'b0000, 1'b1, 1'b1);
  endtask

  task automatic test_press_during_handshake();
    bit acc = 0;
    bit r;
    dut_log.delete();
    hold(4'b0100, 1'b0, 1'b0, 24);
    hold(4'b0000, 1'b0, 1'b0, 24);
    for (int k = 0; k < 30; k++) begin
      r = acc ? 1'b1 : model_press_next(2);
      if (r) acc = 1;
      cycle(4'b0100, r, 1'b0);
    end
    hold(4'b0100, 1'b1, 1'b0, 10);
    checks++; if (!acc || dut_log.size() != 2 || dut_log[0] != 2 || dut_log[1] != 2) begin fails++; $display("FAIL hs_press got=%0d:%0d,%0d exp=2:2,2", dut_log.size(), dut_log[0], dut_log[1]); end
    checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL hs_press_ovf got=%b exp=0", ovf); end
    hold(4'b0000, 1'b1, 1'b0, 24);
  endtask

  task automatic test_random();
    bit [N-1:0] b = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 11) == 0) b[i] = ~b[i];
      cycle(b, (k < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0),
            $urandom_range(0, 40) == 0);
    end
  endtask

  initial begin
    bus.evt_ready = 1'b0;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_overflow();
    test_press_during_handshake();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
Front-end controller for the push-button inputs. It samples N raw buttons on a shared slow tick and debounces each one by requiring STABLE_CNT consecutive agreeing samples. It turns each debounced press (0->1) into a queued event. A round-robin arbiter then serialises those events onto one valid/ready event port that feeds the downstream command FSM.

Parameters:
N_BTN, 4, number of button channels (2..8)
ID_W, 2, width of evt_id; 2^ID_W >= N_BTN required
TICK_DIV, 50000, clk cycles per sample tick (>= 2)
STABLE_CNT, 3, consecutive differing samples needed to flip a debounced level (1..15)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
btn_in  in  N_BTN  raw asynchronous button levels
evt_ready  in  1  consumer accepts evt_id this cycle
ovf_clr  in  1  clears sticky overflow flag
evt_valid  out  1  event offered
evt_id  out  ID_W  index of pressed button; stable while evt_valid=1
btn_level  out  N_BTN  debounced button levels
ovf  out  1  sticky: a press was lost because the channel's previous press was still pending

Behaviour:
- Reset (async, rst=1): all outputs 0; sync FFs, btn_level, per-channel counters, tick counter, pending, rr pointer and ovf all 0; FSM goes to IDLE. Queued events are discarded.
- Synchroniser: each btn_in bit passes through 2 FFs on every clk; the sampled value s[i] is the second FF.
- Tick: counter runs 0..TICK_DIV-1 and wraps; tick=1 for one cycle when count==TICK_DIV-1.
- Per-channel debounce (acts only on tick):
  - s[i]==btn_level[i]: cnt[i]<=0.
  - s[i]!=btn_level[i] and cnt[i]==STABLE_CNT-1: btn_level[i] toggles and cnt[i]<=0.
  - Otherwise cnt[i] increments.
  - Worst-case latency from a steady raw change to btn_level: 2 clk + STABLE_CNT*TICK_DIV clk.
- Press detection: a 0->1 toggle of btn_level[i] sets pending[i] on the same edge. A 1->0 toggle produces no event.
- Overflow: if a press occurs on channel i while pending[i]=1 and pending[i] is not being cleared that cycle, ovf<=1 and the second press is dropped. ovf_clr clears ovf; if set and clear occur in the same cycle, set wins.
- Arbiter FSM, states IDLE and OFFER:
  - IDLE: if pending!=0, select the first set bit scanning upward from ptr with wrap. Load evt_id, drive evt_valid<=1, go to OFFER. If pending==0, stay in IDLE.
  - OFFER: evt_valid=1 and evt_id held. On evt_ready=1: clear pending[evt_id], set ptr<=(evt_id+1) mod N_BTN, evt_valid<=0, go to IDLE. Without evt_ready, stay in OFFER indefinitely (backpressure).
  - Throughput: at most one event per 2 clk, because a mandatory IDLE cycle separates events.
  - Press and handshake on the same channel in the same cycle: the press wins, pending stays 1 and a new event is later offered; no ovf.
  - Pending bits set while in OFFER do not change the current evt_id.
- evt_ready while evt_valid=0 is ignored.
- Press-to-evt_valid latency: pending is set at edge E, evt_valid=1 after edge E+1 (FSM in IDLE).

Test Plan:
Bench configuration for all tests: TICK_DIV=4, STABLE_CNT=3, N_BTN=4.
1. Reset: assert rst for 3 clk, then pulse rst while evt_valid=1 -> all outputs 0 immediately, no further event.
2. Clean press: btn_in[2] 0->1 held, evt_ready=1 -> btn_level[2]=1 within 2+12 clk; evt_valid=1 with evt_id=2 one clk after pending is set; exactly one handshake; releasing the button gives no event.
3. Bounce: toggle btn_in[1] every 4 clk for 40 clk, then hold 1 -> btn_level[1] never glitches, then rises once; exactly one event, evt_id=1.
4. Simultaneous presses: btn 0 and 3 pressed on the same tick, evt_ready=1 -> events 0 then 3, separated by one IDLE clk. Repeat with btn 0 and 3 again -> order 0 then 3 (ptr=0 after 3). With ptr=1 and presses 0 and 3 -> order 3 then 0.
5. Backpressure/overflow: evt_ready=0; press, release and re-press btn0 -> ovf=1; evt_id stays 0; raise evt_ready -> exactly one event. Then ovf_clr=1 -> ovf=0. ovf_clr in the same cycle as a new overflow -> ovf stays 1.
6. Press during handshake: re-press btn2 so pending[2] sets in the accepting cycle -> a second event with id 2 follows, ovf stays 0.
